// File: rtl/trap_ctrl.sv
// Trap sequencer in front of the CSR write/address port: saves mepc/mcause, then vectors to mtvec or returns via mepc.
// Latency: a trap stalls for 3 cycles (mepc write, mcause write, redirect); mret stalls for 1 cycle (redirect).
// Backpressure: none accepted; the core is frozen via stall and all decode events are ignored outside IDLE.
module trap_ctrl #(
    parameter logic [11:0] ADDR_MEPC     = 12'h041,
    parameter logic [11:0] ADDR_MCAUSE   = 12'h042,
    parameter logic [11:0] ADDR_MTVEC    = 12'h005,
    parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
    parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
    parameter logic [31:0] CAUSE_ECALL   = 32'd11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        illegal,
    input  logic        mret,
    input  logic [31:0] pc_in,
    input  logic        inst_csr_w,
    input  logic [11:0] inst_csr_addr,
    input  logic [31:0] inst_csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        csr_w,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        VECTOR,
        RET
    } state_t;

    state_t      state;
    logic [31:0] epc_q;
    logic [31:0] cause_q;
    logic        trap;
    logic [31:0] cause_sel;
    logic [31:0] rdata_aligned;

    assign trap          = ecall | ebreak | illegal;
    assign rdata_aligned = csr_rdata & 32'hFFFF_FFFC;

    always_comb begin
        cause_sel = CAUSE_ECALL;
        if (illegal)
            cause_sel = CAUSE_ILLEGAL;
        else if (ebreak)
            cause_sel = CAUSE_EBREAK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            epc_q   <= 32'd0;
            cause_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // A trap outranks a simultaneous mret; the mret is simply dropped.
                    if (trap) begin
                        state   <= SAVE_EPC;
                        epc_q   <= pc_in & 32'hFFFF_FFFC;
                        cause_q <= cause_sel;
                    end else if (mret) begin
                        state <= RET;
                    end
                end
                SAVE_EPC:   state <= SAVE_CAUSE;
                SAVE_CAUSE: state <= VECTOR;
                VECTOR:     state <= IDLE;
                RET:        state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    always_comb begin
        csr_w          = 1'b0;
        csr_addr       = 12'd0;
        csr_wdata      = 32'd0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    csr_w     = inst_csr_w & ~trap & ~mret;
                    csr_addr  = inst_csr_addr;
                    csr_wdata = inst_csr_wdata;
                end
                SAVE_EPC: begin
                    stall     = 1'b1;
                    csr_w     = 1'b1;
                    csr_addr  = ADDR_MEPC;
                    csr_wdata = epc_q;
                end
                SAVE_CAUSE: begin
                    stall     = 1'b1;
                    csr_w     = 1'b1;
                    csr_addr  = ADDR_MCAUSE;
                    csr_wdata = cause_q;
                end
                VECTOR: begin
                    // The CSR file reads combinationally, so mtvec is valid this same cycle.
                    stall          = 1'b1;
                    csr_addr       = ADDR_MTVEC;
                    redirect_valid = 1'b1;
                    redirect_pc    = rdata_aligned;
                end
                RET: begin
                    stall          = 1'b1;
                    csr_addr       = ADDR_MEPC;
                    redirect_valid = 1'b1;
                    redirect_pc    = rdata_aligned;
                end
                default: begin
                    stall = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: behavioural CSR file, per-cycle expectation timeline, directed plus random stimulus.
module tb_trap_ctrl;

    localparam logic [11:0] MEPC   = 12'h041;
    localparam logic [11:0] MCAUSE = 12'h042;
    localparam logic [11:0] MTVEC  = 12'h005;

    logic        clk;
    logic        rst_n;
    logic        ecall, ebreak, illegal, mret;
    logic [31:0] pc_in;
    logic        inst_csr_w;
    logic [11:0] inst_csr_addr;
    logic [31:0] inst_csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_w;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    trap_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ecall          (ecall),
        .ebreak         (ebreak),
        .illegal        (illegal),
        .mret           (mret),
        .pc_in          (pc_in),
        .inst_csr_w     (inst_csr_w),
        .inst_csr_addr  (inst_csr_addr),
        .inst_csr_wdata (inst_csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_w          (csr_w),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CSR file driven by the DUT: combinational read, write on the rising edge.
    logic [31:0] csr_mem [0:4095];
    assign csr_rdata = csr_mem[csr_addr];
    always @(posedge clk) begin
        if (csr_w)
            csr_mem[csr_addr] <= csr_wdata;
    end

    typedef struct {
        logic        w;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mcsr [0:4095];
    int          checks = 0;
    int          errors = 0;
    int          stall_cnt, redir_cnt, wr_cnt;
    int          cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic w, input logic [11:0] a, input logic [31:0] d,
                                input logic s, input logic rv, input logic [31:0] rpc);
        exp_t x;
        x.w = w; x.addr = a; x.wdata = d; x.stall = s; x.rv = rv; x.rpc = rpc;
        return x;
    endfunction

    // One clock cycle: drive inputs, derive expectation from the architectural rules, check, advance.
    task automatic cycle(input logic e, input logic b, input logic il, input logic m,
                         input logic [31:0] pc, input logic iw, input logic [11:0] ia,
                         input logic [31:0] iwd);
        exp_t x;
        logic [31:0] cause;
        ecall = e; ebreak = b; illegal = il; mret = m; pc_in = pc;
        inst_csr_w = iw; inst_csr_addr = ia; inst_csr_wdata = iwd;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
        end else begin
            x = mk(iw, ia, iwd, 1'b0, 1'b0, 32'd0);
            if (e | b | il) begin
                cause = il ? 32'd2 : (b ? 32'd3 : 32'd11);
                x.w = 1'b0;
                exp_q.push_back(mk(1'b1, MEPC, {pc[31:2], 2'b00}, 1'b1, 1'b0, 32'd0));
                exp_q.push_back(mk(1'b1, MCAUSE, cause, 1'b1, 1'b0, 32'd0));
                exp_q.push_back(mk(1'b0, MTVEC, 32'd0, 1'b1, 1'b1, mcsr[MTVEC] & 32'hFFFF_FFFC));
            end else if (m) begin
                x.w = 1'b0;
                exp_q.push_back(mk(1'b0, MEPC, 32'd0, 1'b1, 1'b1, mcsr[MEPC] & 32'hFFFF_FFFC));
            end
        end
        #2;
        chk("csr_w", {31'd0, csr_w}, {31'd0, x.w});
        chk("csr_addr", {20'd0, csr_addr}, {20'd0, x.addr});
        chk("csr_wdata", csr_wdata, x.wdata);
        chk("stall", {31'd0, stall}, {31'd0, x.stall});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, x.rv});
        chk("redirect_pc", redirect_pc, x.rpc);
        if (stall) stall_cnt++;
        if (redirect_valid) redir_cnt++;
        if (csr_w) wr_cnt++;
        @(posedge clk);
        if (x.w) mcsr[x.addr] = x.wdata;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 12'd0, 32'd0);
    endtask

    // Reset with noisy inputs: every output must read zero and any sequence in flight is dropped.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        ecall = 1'b1; ebreak = 1'b0; illegal = 1'b0; mret = 1'b1; pc_in = 32'h1234_5678;
        inst_csr_w = 1'b1; inst_csr_addr = 12'h300; inst_csr_wdata = 32'hA5A5_A5A5;
        repeat (n) begin
            #2;
            chk("rst csr_w", {31'd0, csr_w}, 32'd0);
            chk("rst stall", {31'd0, stall}, 32'd0);
            chk("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
            chk("rst redirect_pc", redirect_pc, 32'd0);
            if (redirect_valid) redir_cnt++;
            @(posedge clk);
            cyc++;
            #1;
        end
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = 32'd0;
            mcsr[i]    = 32'd0;
        end
        stall_cnt = 0; redir_cnt = 0; wr_cnt = 0;
        do_reset(2);
        idle(1);

        // ecall vectors to mtvec
        cycle(0, 0, 0, 0, 32'd0, 1'b1, MTVEC, 32'h0000_0100);
        stall_cnt = 0; redir_cnt = 0;
        cycle(1, 0, 0, 0, 32'h0000_0040, 1'b0, 12'd0, 32'd0);
        idle(4);
        chk("ecall mepc", csr_mem[MEPC], 32'h40);
        chk("ecall mcause", csr_mem[MCAUSE], 32'd11);
        chk("ecall stall cycles", stall_cnt, 32'd3);
        chk("ecall redirect cycles", redir_cnt, 32'd1);

        // illegal outranks ecall, pc aligned down
        cycle(1, 0, 1, 0, 32'h0000_0086, 1'b0, 12'd0, 32'd0);
        idle(4);
        chk("illegal mcause", csr_mem[MCAUSE], 32'd2);
        chk("illegal mepc", csr_mem[MEPC], 32'h84);

        // mret returns to mepc without writing
        cycle(0, 0, 0, 0, 32'd0, 1'b1, MEPC, 32'h0000_0044);
        stall_cnt = 0; redir_cnt = 0; wr_cnt = 0;
        cycle(0, 0, 0, 1, 32'd0, 1'b1, MTVEC, 32'hFFFF_0000);
        idle(2);
        chk("mret stall cycles", stall_cnt, 32'd1);
        chk("mret redirect cycles", redir_cnt, 32'd1);
        chk("mret csr writes", wr_cnt, 32'd0);
        chk("mret mtvec kept", csr_mem[MTVEC], 32'h100);

        // ebreak suppresses a same-cycle pass-through write
        cycle(0, 1, 0, 0, 32'h0000_0200, 1'b1, MTVEC, 32'hDEAD_BEEC);
        idle(4);
        chk("ebreak mtvec kept", csr_mem[MTVEC], 32'h100);
        chk("ebreak mcause", csr_mem[MCAUSE], 32'd3);

        // reset while in SAVE_CAUSE
        cycle(1, 0, 0, 0, 32'h0000_0300, 1'b0, 12'd0, 32'd0);
        cycle(0, 0, 0, 0, 32'd0, 1'b0, 12'd0, 32'd0);
        redir_cnt = 0;
        do_reset(1);
        idle(3);
        chk("abort mcause kept", csr_mem[MCAUSE], 32'd3);
        chk("abort mepc new", csr_mem[MEPC], 32'h300);
        chk("abort redirects", redir_cnt, 32'd0);

        // ecall held for 5 cycles: two sequences, stall-time writes ignored
        stall_cnt = 0; redir_cnt = 0;
        repeat (5) cycle(1, 0, 0, 0, 32'h0000_0500, 1'b1, MTVEC, 32'h1234_5678);
        idle(5);
        chk("held redirects", redir_cnt, 32'd2);
        chk("held stall cycles", stall_cnt, 32'd6);
        chk("held mtvec kept", csr_mem[MTVEC], 32'h100);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic e, b, il, m, iw;
            logic [11:0] ia;
            logic [31:0] r;
            r  = $urandom;
            e  = (r[2:0] == 3'd0);
            b  = (r[5:3] == 3'd0);
            il = (r[8:6] == 3'd0);
            m  = (r[11:9] == 3'd0);
            iw = r[12];
            case (r[15:13])
                3'd0:    ia = MEPC;
                3'd1:    ia = MCAUSE;
                3'd2:    ia = MTVEC;
                3'd3:    ia = 12'h300;
                default: ia = 12'($urandom_range(0, 4095));
            endcase
            cycle(e, b, il, m, $urandom, iw, ia, $urandom);
        end
        idle(4);
        chk("final mepc", csr_mem[MEPC], mcsr[MEPC]);
        chk("final mcause", csr_mem[MCAUSE], mcsr[MCAUSE]);
        chk("final mtvec", csr_mem[MTVEC], mcsr[MTVEC]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
